arm_fetch: RTL and testbench
============================

# arm_fetch

Instruction fetch stage directly upstream of `arm_decode`. It holds the fetch PC and issues word requests to instruction memory over a req/ack handshake. Returned words are buffered in a 2-entry prefetch queue, and each is presented to decode with its PC under a valid/ready handshake. A taken branch flushes the queue, drops any in-flight fetch and redirects the PC.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: fetch address after reset. Bits [1:0] must be 0.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  word-aligned fetch address. Bits [1:0] are always 0.
- `imem_ack`  in  1  `imem_rdata` valid this cycle. Completes the current request. Ignored when `imem_req`=0.
- `imem_rdata`  in  32  fetched instruction word.
- `branch_valid`  in  1  redirect request from the execute stage. Single-cycle pulse.
- `branch_target`  in  32  redirect address. Bits [1:0] are forced to 0 internally.
- `inst_valid`  out  1  `inst`/`inst_pc` hold a valid instruction.
- `inst`  out  32  instruction to decode. Feeds `arm_decode.inst`.
- `inst_pc`  out  32  address of `inst`.
- `inst_ready`  in  1  decode accepts `inst` this cycle.

## Operation
- State machine with states IDLE, RUN and DISCARD.
  - Reset enters IDLE.
  - IDLE moves to RUN unconditionally on the next edge.
- Registers:
  - `fetch_pc`, 32 bits.
  - 2-entry queue of {word, pc}, with a 1-bit read pointer, a 1-bit write pointer and a 2-bit `count` (0..2).
- `imem_req` is combinational:
  - 1 in RUN when `count`<2.
  - 1 in DISCARD.
  - 0 otherwise.
- `imem_addr` = `fetch_pc` in RUN. In DISCARD it is the address of the aborted request, latched at the branch.
- Request rule: once asserted, `imem_req` and `imem_addr` stay stable until `imem_ack`. A pop only lowers `count`, so this holds.
  - At most one request is outstanding.
  - Memory may ack in the same cycle as the request (zero wait) or any later cycle.
- Push: happens in RUN on `imem_req`&`imem_ack` when `branch_valid`=0.
  - Writes {`imem_rdata`, `fetch_pc`} at the write pointer.
  - Then `fetch_pc` += 4, wrapping modulo 2^32. `32'hFFFF_FFFC` wraps to 0.
- Pop: on `inst_valid`&`inst_ready`; the read pointer advances.
  - `inst_valid` = (`count`!=0).
  - `inst`/`inst_pc` = queue entry at the read pointer. They must not change while `inst_valid`=1 and `inst_ready`=0.
- Simultaneous push and pop: `count` is unchanged. This can occur only when `count`=1.
- Branch (`branch_valid`=1), highest priority:
  - Queue flushes: `count`←0 and both pointers reset. Any same-cycle pop or push is discarded.
  - `fetch_pc`←`branch_target`&~3.
  - If `imem_req`=1 and `imem_ack`=0 (fetch in flight): go to DISCARD and latch the old `imem_addr`.
  - Otherwise stay in or enter RUN. A same-cycle ack's data is dropped.
- DISCARD:
  - Keeps `imem_req`=1 at the aborted address.
  - On `imem_ack`, the data is dropped and the state returns to RUN.
  - A further `branch_valid` during DISCARD only updates `fetch_pc`; the state stays in DISCARD.
- Reset mid-operation: asynchronously clears everything to reset values, whatever the state.

## Timing
- Reset values while `rst_n`=0 and in IDLE:
  - `imem_req`=0.
  - `imem_addr`=`RESET_PC`.
  - `inst_valid`=0.
  - `inst`=0 and `inst_pc`=0 (the queue is cleared).
  - `fetch_pc`=`RESET_PC`.
- First `imem_req`=1 is in the second cycle after `rst_n` rises (IDLE lasts one cycle).
- Fetch latency: an ack at edge-cycle n gives `inst_valid`=1 in cycle n+1.
- Throughput: with zero-wait memory and `inst_ready`=1, one instruction per cycle is sustained and `count` holds at 1.
- Backpressure: with `inst_ready`=0, two words are fetched, then `imem_req`=0 from the cycle `count` reaches 2.
- Branch in cycle n with no fetch in flight:
  - `inst_valid`=0 in n+1.
  - `imem_req`=1 with `imem_addr`=target in n+1.
  - First target instruction is valid in n+2 with zero-wait memory.
- Branch with a fetch in flight: the target request starts in the cycle after the discarded ack.

## Test plan
- Reset release with `RESET_PC`=`32'h100` and zero-wait memory, `inst_ready`=1 → requests go to 0x100, 0x104, 0x108 on consecutive cycles. `inst_pc` shows 0x100, 0x104, 0x108 with matching `inst`, one per cycle.
- `inst_ready`=0 held for 5 cycles → exactly two acks accepted and `imem_req`=0 thereafter. `inst`/`inst_pc` stay stable at 0x100. Releasing `inst_ready` delivers 0x100, then 0x104, then the fetch of 0x108 resumes.
- 3-wait-state memory, `branch_valid` with target `32'h2003` asserted one cycle after a request to 0x10C → `imem_addr` stays 0x10C until its ack, and that data is never presented. The next request is 0x2000, and the next `inst_pc` is 0x2000.
- `branch_valid` in the same cycle as `imem_ack` and an `inst_valid`&`inst_ready` pop with `count`=2 → `inst_valid`=0 in the next cycle, `count`=0, and the next request is at the target.
- `fetch_pc` at `32'hFFFF_FFFC` → after that ack, the next request is at 0x0 and `inst_pc` sequence is FFFF_FFFC, 0000_0000.
- `rst_n` pulled low in DISCARD with `count`=1 → all outputs take reset values immediately. After release, fetch restarts at `RESET_PC`, with no stale instruction or late ack accepted.

Source files
------------

// File: rtl/arm_fetch.sv
// -----------------------------------------------------------------------------
// arm_fetch
//   Instruction fetch stage feeding arm_decode. Holds the fetch PC, issues
//   word requests to instruction memory over a req/ack handshake, buffers the
//   returned words in a 2-entry prefetch queue and presents them to decode with
//   their PC under a valid/ready handshake. A taken branch flushes the queue,
//   redirects the PC and, if a request is still in flight, waits for (and
//   drops) its ack before fetching from the target.
//
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   imem_req      out  fetch request (stable until imem_ack)
//   imem_addr     out  word-aligned fetch address
//   imem_ack      in   imem_rdata valid, completes the current request
//   imem_rdata    in   fetched instruction word
//   branch_valid  in   single-cycle redirect pulse from execute
//   branch_target in   redirect address (bits [1:0] ignored)
//   inst_valid    out  inst/inst_pc hold a valid instruction
//   inst          out  instruction word to decode
//   inst_pc       out  address of inst
//   inst_ready    in   decode accepts inst this cycle
// -----------------------------------------------------------------------------
module arm_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] fetch_pc_r;
  logic [31:0] disc_addr_r;
  logic [31:0] q_word_r [0:1];
  logic [31:0] q_pc_r   [0:1];
  logic        rd_ptr_r;
  logic        wr_ptr_r;
  logic [1:0]  count_r;

  logic        push_s;
  logic        pop_s;
  logic        in_flight_s;

  // Memory-side request: RUN fetches while the queue has room; DISCARD keeps
  // the aborted request alive so the handshake completes cleanly.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fetch_pc_r;
    case (state_r)
      RUN: begin
        imem_req  = (count_r != 2'd2);
        imem_addr = fetch_pc_r;
      end
      DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = disc_addr_r;
      end
      default: begin
        imem_req  = 1'b0;
        imem_addr = fetch_pc_r;
      end
    endcase
  end

  // Decode-side view of the queue head plus the push/pop qualifiers.
  // A branch cancels any same-cycle push or pop.
  always_comb begin
    inst_valid  = (count_r != 2'd0);
    inst        = q_word_r[rd_ptr_r];
    inst_pc     = q_pc_r[rd_ptr_r];
    push_s      = (state_r == RUN) && imem_req && imem_ack && !branch_valid;
    pop_s       = inst_valid && inst_ready && !branch_valid;
    in_flight_s = imem_req && !imem_ack;
  end

  // Next-state logic; a branch overrides everything else.
  always_comb begin
    state_nxt_s = state_r;
    if (branch_valid) begin
      if (in_flight_s) begin
        state_nxt_s = DISCARD;
      end else begin
        state_nxt_s = RUN;
      end
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = RUN;
        RUN:     state_nxt_s = RUN;
        DISCARD: begin
          if (imem_ack) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = DISCARD;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Fetch PC, aborted-address latch and prefetch queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r  <= RESET_PC;
      disc_addr_r <= RESET_PC;
      q_word_r[0] <= 32'd0;
      q_word_r[1] <= 32'd0;
      q_pc_r[0]   <= 32'd0;
      q_pc_r[1]   <= 32'd0;
      rd_ptr_r    <= 1'b0;
      wr_ptr_r    <= 1'b0;
      count_r     <= 2'd0;
    end else if (branch_valid) begin
      fetch_pc_r <= branch_target & ~32'd3;
      rd_ptr_r   <= 1'b0;
      wr_ptr_r   <= 1'b0;
      count_r    <= 2'd0;
      // In DISCARD imem_addr already equals disc_addr_r, so this is a hold.
      if (in_flight_s) begin
        disc_addr_r <= imem_addr;
      end else begin
        disc_addr_r <= disc_addr_r;
      end
    end else begin
      if (push_s) begin
        q_word_r[wr_ptr_r] <= imem_rdata;
        q_pc_r[wr_ptr_r]   <= fetch_pc_r;
        wr_ptr_r           <= ~wr_ptr_r;
        fetch_pc_r         <= fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_fetch.sv
// -----------------------------------------------------------------------------
// tb_arm_fetch
//   Directed bench for arm_fetch (RESET_PC = 0x100). A behavioural memory with
//   programmable wait states answers requests; a small model of the fetch
//   stage pushes {pc, word} onto a scoreboard whenever an ack should be
//   accepted, and every cycle the queue head is compared against inst/inst_pc.
//   Request/address/valid outputs are compared against the model each cycle.
// -----------------------------------------------------------------------------
module tb_arm_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int          n_cmp = 0;
  int          n_err = 0;
  int          ws;
  int          waited;
  int          n_acks;
  bit          force_ack;

  logic [63:0] sb [$];
  logic [31:0] m_pc;
  logic [31:0] m_disc_addr;
  bit          m_disc;
  bit          m_run;

  arm_fetch #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hE3A0_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // One clock cycle, entered just after a falling edge with this cycle's
  // decode/branch inputs already driven.
  task automatic cycle();
    logic        m_req;
    logic [31:0] m_addr;
    logic [63:0] head;
    bit          pop;
    m_req  = m_disc ? 1'b1 : (m_run && (sb.size() < 2));
    m_addr = m_disc ? m_disc_addr : m_pc;
    chk("imem_req", 32'(imem_req), 32'(m_req));
    chk("imem_addr", imem_addr, m_addr);
    chk("inst_valid", 32'(inst_valid), 32'(sb.size() != 0));

    imem_ack   = force_ack || (imem_req && (waited >= ws));
    imem_rdata = word_of(imem_addr);
    if (imem_req && imem_ack) n_acks++;

    if (sb.size() != 0) begin
      head = sb[0];
      chk("inst_pc", inst_pc, head[63:32]);
      chk("inst", inst, head[31:0]);
    end
    pop = (sb.size() != 0) && inst_ready && !branch_valid;

    if (branch_valid) begin
      sb.delete();
      if (m_req && !imem_ack) begin
        m_disc_addr = m_addr;
        m_disc      = 1'b1;
      end else begin
        m_disc = 1'b0;
      end
      m_pc  = branch_target & ~32'd3;
      m_run = 1'b1;
    end else if (m_disc) begin
      if (imem_ack) m_disc = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1;
    end else begin
      if (pop) void'(sb.pop_front());
      if (m_req && imem_ack) begin
        sb.push_back({m_pc, word_of(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end

    if (imem_req && imem_ack) waited = 0;
    else if (imem_req)        waited = waited + 1;
    else                      waited = 0;

    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Assert reset (asynchronously), check reset outputs, release mid-cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    sb.delete();
    m_pc         = RST_PC;
    m_disc_addr  = RST_PC;
    m_disc       = 1'b0;
    m_run        = 1'b0;
    waited       = 0;
    n_acks       = 0;
    branch_valid = 1'b0;
    imem_ack     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b1;
    imem_ack      = 1'b0;
    imem_rdata    = 32'd0;
    branch_valid  = 1'b0;
    branch_target = 32'd0;
    inst_ready    = 1'b1;
    force_ack     = 1'b0;
    ws            = 0;
    #2;

    // Streaming from reset: zero-wait memory, decode always ready.
    do_reset();
    ws = 0; inst_ready = 1'b1;
    chk("idle_no_req", 32'(imem_req), 32'd0);
    repeat (8) cycle();

    // Backpressure: two words fetched, then request drops; release drains.
    do_reset();
    inst_ready = 1'b0;
    repeat (7) cycle();
    chk("bp_acks", 32'(n_acks), 32'd2);
    chk("bp_req_low", 32'(imem_req), 32'd0);
    inst_ready = 1'b1;
    repeat (5) cycle();

    // Branch while a 3-wait-state fetch of 0x10C is in flight.
    do_reset();
    ws = 3; inst_ready = 1'b1;
    for (int i = 0; i < 100 && !(imem_req && imem_addr == 32'h0000_010C); i++) cycle();
    chk("reach_10c", imem_addr, 32'h0000_010C);
    cycle();
    branch_valid  = 1'b1;
    branch_target = 32'h0000_2003;
    cycle();
    branch_valid  = 1'b0;
    for (int i = 0; i < 20 && !(imem_req && imem_addr == 32'h0000_2000); i++) cycle();
    chk("redirect_2000", imem_addr, 32'h0000_2000);
    repeat (10) cycle();

    // Branch together with an ignored ack and a pop while the queue is full.
    do_reset();
    ws = 0; inst_ready = 1'b0;
    repeat (4) cycle();
    chk("full_req_low", 32'(imem_req), 32'd0);
    inst_ready    = 1'b1;
    force_ack     = 1'b1;
    branch_valid  = 1'b1;
    branch_target = 32'h0000_3000;
    cycle();
    force_ack     = 1'b0;
    branch_valid  = 1'b0;
    chk("flush_valid", 32'(inst_valid), 32'd0);
    chk("flush_req", 32'(imem_req), 32'd1);
    chk("flush_addr", imem_addr, 32'h0000_3000);
    repeat (4) cycle();

    // Address wrap at the top of memory.
    branch_valid  = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    cycle();
    branch_valid  = 1'b0;
    chk("wrap_first", imem_addr, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_next", imem_addr, 32'h0000_0000);
    repeat (3) cycle();

    // Reset while discarding an aborted fetch; a late ack during IDLE is ignored.
    ws = 3;
    for (int i = 0; i < 20 && !(imem_req && waited == 1); i++) cycle();
    chk("disc_setup", 32'(waited), 32'd1);
    branch_valid  = 1'b1;
    branch_target = 32'h0000_0500;
    cycle();
    branch_valid  = 1'b0;
    chk("in_discard", 32'(m_disc), 32'd1);
    cycle();
    do_reset();
    force_ack = 1'b1;
    cycle();
    force_ack = 1'b0;
    ws = 0; inst_ready = 1'b1;
    repeat (6) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
